// File: rtl/dmem_param.sv
// Parametrised single-port synchronous data memory.
// Byte-lane write enables (byteEn[0] selects the most significant byte),
// a configurable read latency and an optional zero-fill of every word after
// reset. While the zero-fill runs, memRdy is low and requests are ignored.
module dmem_param #(
    parameter int DATA_W       = 64,
    parameter int ADDR_W       = 8,
    parameter int DEPTH        = 256,
    parameter int RD_LAT       = 1,
    parameter int CLR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                memEn,
    input  logic                memWrEn,
    input  logic [0:ADDR_W-1]   memAddr,
    input  logic [0:DATA_W-1]   dataIn,
    input  logic [0:DATA_W/8-1] byteEn,
    output logic [0:DATA_W-1]   dataOut,
    output logic                dataValid,
    output logic                memRdy
);

    localparam int NBYTES = DATA_W / 8;
    // Array index width; the upper address bits only matter for the range check.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (CLR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    logic [0:DATA_W-1] mem_r [0:DEPTH-1];

    state_t            state_r;
    state_t            stateNext_s;
    logic [IDX_W-1:0]  clrPtr_r;
    logic              memRdy_r;

    logic              inRange_s;
    logic              wrAcc_s;
    logic              rdAcc_s;
    logic [IDX_W-1:0]  wordIdx_s;
    logic [0:DATA_W-1] rdWord_s;

    logic [0:DATA_W-1] pipeData_r [1:RD_LAT];
    logic [1:RD_LAT]   pipeValid_r;

    // The zero-extended compare also covers DEPTH == 2**ADDR_W.
    assign inRange_s = ({1'b0, memAddr} < DEPTH_L);
    assign wordIdx_s = IDX_W'(memAddr);
    // Requests count only once the block is ready; out-of-range writes are dropped.
    assign wrAcc_s   = memEn & memWrEn & memRdy_r & inRange_s;
    assign rdAcc_s   = memEn & ~memWrEn & memRdy_r;

    // Next-state logic: the clear sweep ends on the edge that clears the last word.
    always_comb begin
        stateNext_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (clrPtr_r == LAST_IDX) begin
                    stateNext_s = ST_READY;
                end else begin
                    stateNext_s = ST_CLEAR;
                end
            end
            ST_READY: stateNext_s = ST_READY;
            default:  stateNext_s = RESET_STATE;
        endcase
    end

    // State register, clear pointer and registered ready flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= RESET_STATE;
            clrPtr_r <= '0;
            memRdy_r <= 1'b0;
        end else begin
            state_r  <= stateNext_s;
            memRdy_r <= (stateNext_s == ST_READY);
            if (state_r == ST_CLEAR) begin
                clrPtr_r <= clrPtr_r + IDX_W'(1);
            end
        end
    end

    // Storage write port: zero-fill during CLEAR, byte-masked writes when ready.
    // The array itself has no reset so contents survive reset when not cleared.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_r == ST_CLEAR) begin
                mem_r[clrPtr_r] <= '0;
            end else if (wrAcc_s) begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (byteEn[i]) begin
                        mem_r[wordIdx_s][8*i +: 8] <= dataIn[8*i +: 8];
                    end
                end
            end
        end
    end

    // Word captured at the issue edge; zero for idle cycles and out-of-range reads.
    always_comb begin
        rdWord_s = '0;
        if (rdAcc_s && inRange_s) begin
            rdWord_s = mem_r[wordIdx_s];
        end else begin
            rdWord_s = '0;
        end
    end

    // Read pipeline; reset flushes reads in flight so they never surface.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipeValid_r <= '0;
            for (int i = 1; i <= RD_LAT; i++) begin
                pipeData_r[i] <= '0;
            end
        end else begin
            pipeValid_r[1] <= rdAcc_s;
            pipeData_r[1]  <= rdWord_s;
            for (int i = 2; i <= RD_LAT; i++) begin
                pipeValid_r[i] <= pipeValid_r[i-1];
                pipeData_r[i]  <= pipeData_r[i-1];
            end
        end
    end

    assign dataOut   = pipeData_r[RD_LAT];
    assign dataValid = pipeValid_r[RD_LAT];
    assign memRdy    = memRdy_r;

endmodule

// File: tb/tb_dmem_param.sv
// Directed testbench for dmem_param.
// dutA: DEPTH=16, RD_LAT=3, zero-fill after reset.
// dutB: DEPTH=200, RD_LAT=1, contents retained across reset.
module tb_dmem_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        resetA, memEnA, memWrEnA, validA, rdyA;
    logic [0:7]  addrA, beA;
    logic [0:63] dinA, doutA;

    logic        resetB, memEnB, memWrEnB, validB, rdyB;
    logic [0:7]  addrB, beB;
    logic [0:63] dinB, doutB;

    dmem_param #(.DATA_W(64), .ADDR_W(8), .DEPTH(16), .RD_LAT(3), .CLR_ON_RESET(1)) dutA (
        .clk(clk), .reset(resetA), .memEn(memEnA), .memWrEn(memWrEnA), .memAddr(addrA),
        .dataIn(dinA), .byteEn(beA), .dataOut(doutA), .dataValid(validA), .memRdy(rdyA)
    );

    dmem_param #(.DATA_W(64), .ADDR_W(8), .DEPTH(200), .RD_LAT(1), .CLR_ON_RESET(0)) dutB (
        .clk(clk), .reset(resetB), .memEn(memEnB), .memWrEn(memWrEnB), .memAddr(addrB),
        .dataIn(dinB), .byteEn(beB), .dataOut(doutB), .dataValid(validB), .memRdy(rdyB)
    );

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic driveA(input logic en, input logic wr, input logic [0:7] a,
                          input logic [0:63] d, input logic [0:7] be);
        memEnA = en; memWrEnA = wr; addrA = a; dinA = d; beA = be;
    endtask

    task automatic driveB(input logic en, input logic wr, input logic [0:7] a,
                          input logic [0:63] d, input logic [0:7] be);
        memEnB = en; memWrEnB = wr; addrB = a; dinB = d; beB = be;
    endtask

    task automatic test_reset;
        int cyc;
        resetA = 1'b1;
        driveA(1'b0, 1'b0, 8'd0, 64'd0, 8'h00);
        tick(); tick();
        checks++;
        if (doutA !== 64'd0) begin errors++; $display("FAIL reset_dataOut got %h exp 0", doutA); end
        checks++;
        if (validA !== 1'b0) begin errors++; $display("FAIL reset_dataValid got %b exp 0", validA); end
        checks++;
        if (rdyA !== 1'b0) begin errors++; $display("FAIL reset_memRdy got %b exp 0", rdyA); end
        resetA = 1'b0;
        cyc = 0;
        while (rdyA !== 1'b1 && cyc < 100) begin tick(); cyc++; end
        checks++;
        if (cyc !== 16) begin errors++; $display("FAIL initial_clear_len got %0d exp 16", cyc); end
    endtask

    task automatic test_clear;
        int cyc;
        logic seenValid;
        logic expV;
        logic [0:63] expD;
        for (int k = 0; k < 16; k++) begin
            driveA(1'b1, 1'b1, 8'(k), 64'hA5A5_0000_0000_0000 + 64'(k), 8'hFF);
            tick();
        end
        driveA(1'b1, 1'b0, 8'd3, 64'd0, 8'h00);
        tick();
        resetA = 1'b1;
        tick(); tick();
        resetA = 1'b0;
        cyc = 0;
        seenValid = 1'b0;
        while (rdyA !== 1'b1 && cyc < 100) begin
            if (validA !== 1'b0) seenValid = 1'b1;
            tick();
            cyc++;
        end
        checks++;
        if (cyc !== 16) begin errors++; $display("FAIL clear_len got %0d exp 16", cyc); end
        checks++;
        if (seenValid !== 1'b0) begin errors++; $display("FAIL clear_no_valid got %b exp 0", seenValid); end
        for (int c = 0; c < 20; c++) begin
            expV = (c >= 3 && c < 19);
            expD = 64'd0;
            checks++;
            if ({validA, doutA} !== {expV, expD}) begin
                errors++;
                $display("FAIL clear_readback c=%0d got v=%b d=%h exp v=%b d=%h", c, validA, doutA, expV, expD);
            end
            if (c < 16) driveA(1'b1, 1'b0, 8'(c), 64'd0, 8'h00);
            else        driveA(1'b0, 1'b0, 8'd0, 64'd0, 8'h00);
            tick();
        end
    endtask

    task automatic test_byte_write;
        logic expV;
        logic [0:63] expD;
        for (int c = 0; c < 9; c++) begin
            expV = (c == 5 || c == 7);
            expD = expV ? 64'hAA11_2233_4455_6611 : 64'd0;
            checks++;
            if ({validA, doutA} !== {expV, expD}) begin
                errors++;
                $display("FAIL byte_write c=%0d got v=%b d=%h exp v=%b d=%h", c, validA, doutA, expV, expD);
            end
            case (c)
                0:       driveA(1'b1, 1'b1, 8'd5, 64'h0011_2233_4455_6677, 8'hFF);
                1:       driveA(1'b1, 1'b1, 8'd5, 64'hAABB_CCDD_EEFF_0011, 8'b1000_0001);
                2:       driveA(1'b1, 1'b0, 8'd5, 64'd0, 8'h00);
                3:       driveA(1'b1, 1'b1, 8'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
                4:       driveA(1'b1, 1'b0, 8'd5, 64'd0, 8'hFF);
                default: driveA(1'b0, 1'b0, 8'd0, 64'd0, 8'h00);
            endcase
            tick();
        end
    endtask

    task automatic test_latency_order;
        logic expV;
        logic [0:63] expD;
        for (int c = 0; c < 9; c++) begin
            expV = (c == 4 || c == 6);
            expD = (c == 4) ? 64'h1 : ((c == 6) ? 64'h2 : 64'd0);
            checks++;
            if ({validA, doutA} !== {expV, expD}) begin
                errors++;
                $display("FAIL latency_order c=%0d got v=%b d=%h exp v=%b d=%h", c, validA, doutA, expV, expD);
            end
            case (c)
                0:       driveA(1'b1, 1'b1, 8'd2, 64'h1, 8'hFF);
                1:       driveA(1'b1, 1'b0, 8'd2, 64'd0, 8'h00);
                2:       driveA(1'b1, 1'b1, 8'd2, 64'h2, 8'hFF);
                3:       driveA(1'b1, 1'b0, 8'd2, 64'd0, 8'h00);
                default: driveA(1'b0, 1'b0, 8'd0, 64'd0, 8'h00);
            endcase
            tick();
        end
    endtask

    task automatic test_back_to_back;
        logic expV;
        logic [0:63] expD;
        for (int k = 0; k < 8; k++) begin
            driveA(1'b1, 1'b1, 8'(k), 64'(100 + k), 8'hFF);
            tick();
        end
        driveA(1'b0, 1'b0, 8'd0, 64'd0, 8'h00);
        tick();
        for (int c = 0; c < 14; c++) begin
            expV = (c >= 3 && c < 11);
            expD = expV ? 64'(100 + c - 3) : 64'd0;
            checks++;
            if ({validA, doutA} !== {expV, expD}) begin
                errors++;
                $display("FAIL back_to_back c=%0d got v=%b d=%h exp v=%b d=%h", c, validA, doutA, expV, expD);
            end
            if (c < 8) driveA(1'b1, 1'b0, 8'(c), 64'd0, 8'h00);
            else       driveA(1'b0, 1'b0, 8'd0, 64'd0, 8'h00);
            tick();
        end
    endtask

    task automatic test_reset_mid_clear;
        int cyc;
        logic seenValid;
        seenValid = 1'b0;
        driveA(1'b1, 1'b0, 8'd3, 64'd0, 8'h00);
        tick();
        driveA(1'b0, 1'b0, 8'd0, 64'd0, 8'h00);
        resetA = 1'b1;
        tick();
        resetA = 1'b0;
        for (int c = 0; c < 9; c++) begin
            if (validA !== 1'b0 || rdyA !== 1'b0) seenValid = 1'b1;
            tick();
        end
        checks++;
        if (seenValid !== 1'b0) begin errors++; $display("FAIL flushed_read got %b exp 0", seenValid); end
        resetA = 1'b1;
        tick();
        resetA = 1'b0;
        cyc = 0;
        seenValid = 1'b0;
        while (rdyA !== 1'b1 && cyc < 100) begin
            if (validA !== 1'b0) seenValid = 1'b1;
            tick();
            cyc++;
        end
        checks++;
        if (cyc !== 16) begin errors++; $display("FAIL restart_clear_len got %0d exp 16", cyc); end
        checks++;
        if (seenValid !== 1'b0) begin errors++; $display("FAIL restart_no_valid got %b exp 0", seenValid); end
    endtask

    task automatic test_no_clear_reset;
        resetB = 1'b1;
        driveB(1'b0, 1'b0, 8'd0, 64'd0, 8'h00);
        tick();
        checks++;
        if ({rdyB, validB, doutB} !== {1'b0, 1'b0, 64'd0}) begin
            errors++;
            $display("FAIL b_reset got rdy=%b v=%b d=%h exp 0 0 0", rdyB, validB, doutB);
        end
        resetB = 1'b0;
        checks++;
        if (rdyB !== 1'b0) begin errors++; $display("FAIL b_rdy_cycle0 got %b exp 0", rdyB); end
        tick();
        checks++;
        if (rdyB !== 1'b1) begin errors++; $display("FAIL b_rdy_cycle1 got %b exp 1", rdyB); end
    endtask

    task automatic test_out_of_range;
        logic expV;
        logic [0:63] expD;
        for (int c = 0; c < 8; c++) begin
            expV = (c == 3 || c == 5 || c == 6);
            expD = (c == 5) ? 64'h199 : ((c == 6) ? 64'h33 : 64'd0);
            checks++;
            if ({validB, doutB} !== {expV, expD}) begin
                errors++;
                $display("FAIL out_of_range c=%0d got v=%b d=%h exp v=%b d=%h", c, validB, doutB, expV, expD);
            end
            case (c)
                0:       driveB(1'b1, 1'b1, 8'd3, 64'h33, 8'hFF);
                1:       driveB(1'b1, 1'b1, 8'd250, 64'hFFFF, 8'hFF);
                2:       driveB(1'b1, 1'b0, 8'd250, 64'd0, 8'h00);
                3:       driveB(1'b1, 1'b1, 8'd199, 64'h199, 8'hFF);
                4:       driveB(1'b1, 1'b0, 8'd199, 64'd0, 8'h00);
                5:       driveB(1'b1, 1'b0, 8'd3, 64'd0, 8'h00);
                default: driveB(1'b0, 1'b0, 8'd0, 64'd0, 8'h00);
            endcase
            tick();
        end
    endtask

    task automatic test_retention;
        resetB = 1'b1;
        tick();
        resetB = 1'b0;
        // Not ready yet: this write must be ignored.
        driveB(1'b1, 1'b1, 8'd3, 64'hDEAD, 8'hFF);
        checks++;
        if (rdyB !== 1'b0) begin errors++; $display("FAIL ret_rdy_cycle0 got %b exp 0", rdyB); end
        tick();
        checks++;
        if ({rdyB, validB, doutB} !== {1'b1, 1'b0, 64'd0}) begin
            errors++;
            $display("FAIL ret_cycle1 got rdy=%b v=%b d=%h exp 1 0 0", rdyB, validB, doutB);
        end
        driveB(1'b1, 1'b0, 8'd3, 64'd0, 8'h00);
        tick();
        driveB(1'b0, 1'b0, 8'd0, 64'd0, 8'h00);
        checks++;
        if ({validB, doutB} !== {1'b1, 64'h33}) begin
            errors++;
            $display("FAIL ret_read3 got v=%b d=%h exp v=1 d=%h", validB, doutB, 64'h33);
        end
        tick();
        checks++;
        if ({validB, doutB} !== {1'b0, 64'd0}) begin
            errors++;
            $display("FAIL ret_after got v=%b d=%h exp v=0 d=0", validB, doutB);
        end
    endtask

    initial begin
        resetB = 1'b1;
        driveB(1'b0, 1'b0, 8'd0, 64'd0, 8'h00);
        test_reset();
        test_clear();
        test_byte_write();
        test_latency_order();
        test_back_to_back();
        test_reset_mid_clear();
        test_no_clear_reset();
        test_out_of_range();
        test_retention();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_param.md
Name: dmem_param

Overview:
Parametrised single-port synchronous data memory for the Cardinal processor and NIC-side buffers. It generalises the fixed 64x256 data memory with configurable width, depth and read latency, and adds per-byte write enables. It also provides a hardware clear-on-reset sequencer and an explicit ready/valid indication. It sits between the processor MEM stage (or NIC) and storage, one request per cycle.

Parameters:
DATA_W, 64, data word width in bits; multiple of 8, 8..256.
ADDR_W, 8, address width in bits.
DEPTH, 256, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W.
RD_LAT, 1, read latency in cycles from the issue edge to the dataValid cycle; legal values 1..3.
CLR_ON_RESET, 1, 1 = zero all words after reset via the sequencer; 0 = contents untouched, ready immediately.

Ports:
clk  input  1  system clock, all logic on posedge.
reset  input  1  synchronous, active-high reset.
memEn  input  1  request valid.
memWrEn  input  1  1 = write, 0 = read; qualified by memEn.
memAddr  input  [0:ADDR_W-1]  word address.
dataIn  input  [0:DATA_W-1]  write data.
byteEn  input  [0:DATA_W/8-1]  byte write enables; byteEn[i] covers dataIn[8i:8i+7], so byteEn[0] is the MSB byte.
dataOut  output  [0:DATA_W-1]  read data; 0 whenever dataValid=0.
dataValid  output  1  1-cycle pulse, dataOut valid.
memRdy  output  1  block accepts requests.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: dataOut=0, dataValid=0, memRdy=0. The read pipeline is flushed, clrPtr=0, and the state is set to CLEAR (if CLR_ON_RESET=1) or READY (if CLR_ON_RESET=0).
- Registered outputs: memRdy is a registered state bit. With CLR_ON_RESET=0 it becomes 1 at the first posedge with reset low.
- State CLEAR:
  - Each posedge writes all-zero to MEM[clrPtr], then clrPtr++.
  - On the edge that clears DEPTH-1, go to READY and set memRdy=1.
  - memRdy is therefore high in cycle DEPTH, counting the first cycle with reset low as cycle 0.
- State READY: stays in READY until reset.
- Requests while memRdy=0 are ignored: no write, no dataValid, no error.
- Reset asserted mid-CLEAR restarts the clear from address 0. A read in flight when reset asserts never produces dataValid.
- Write (memEn & memWrEn & memRdy at posedge):
  - Each byte with byteEn=1 is updated from dataIn; bytes with byteEn=0 keep their value.
  - byteEn all-zero means no change.
  - Writes produce no dataValid.
- Read (memEn & !memWrEn & memRdy at posedge):
  - MEM[memAddr] is captured at the issue edge into pipeline stage 1.
  - Data moves through RD_LAT-1 further registers.
  - dataValid=1 and dataOut=captured word in the cycle RD_LAT cycles after the issue cycle (RD_LAT=1: the cycle right after issue).
  - byteEn is ignored for reads.
- Back-to-back: one request per cycle at full throughput, reads and writes in any mix. Read results appear in issue order, one per cycle.
- Ordering: the value a read returns is fixed at its issue edge.
  - A write issued in a later cycle does not alter a read already in the pipeline, even for RD_LAT>1.
  - A read issued the cycle after a write to the same address returns the new data.
- Out of range (memAddr >= DEPTH): writes are dropped; reads return dataOut=0 with dataValid=1 at normal latency.
- Content retention: with CLR_ON_RESET=0, reset does not alter memory contents.

Test Plan:
- Clear sequence: DATA_W=64, DEPTH=16, CLR_ON_RESET=1; preload via prior writes, pulse reset 2 cycles, hold memEn=1 reads throughout.
  -> memRdy rises exactly in cycle 16 after reset drops; no dataValid before that; subsequent reads of addresses 0..15 return 0.
- Byte write: write 64'h0011223344556677 to addr 5 with byteEn=8'hFF, then dataIn=64'hAABBCCDDEEFF0011 with byteEn=8'b1000_0001, then read addr 5.
  -> 64'hAA11223344556611.
- Latency and ordering: RD_LAT=3; write addr 2=64'h1, read addr 2, next cycle write addr 2=64'h2, next cycle read addr 2.
  -> dataValid pulses 3 cycles after each read issue, returning 64'h1 then 64'h2.
- Throughput: 8 consecutive reads of addresses 0..7, preloaded with values 100..107.
  -> dataValid high for 8 consecutive cycles with 100..107 in order; dataOut=0 in the cycles before and after.
- Reset mid-clear and during reads: DEPTH=16, assert reset at clrPtr=9, deassert.
  -> memRdy rises 16 cycles after deassert. A read in flight at reset assertion yields no dataValid.
- Out of range and no-clear: DEPTH=200, ADDR_W=8, CLR_ON_RESET=0; write addr 250 = 64'hFFFF, then read addr 250; reset, then read a previously written addr 3 = 64'h33.
  -> the addr 250 read returns 0 with dataValid=1; memRdy=1 one cycle after reset; the addr 3 read returns 64'h33.
